// File: rtl/lsu_block_arbiter.sv
// Round-robin arbiter sharing one dcache request/response channel among NUM_REQS LSU blocks.
// Requests pass through a 2-entry elastic buffer; responses are steered back by the tag's low sel bits.
module lsu_block_arbiter #(
  parameter int NUM_REQS    = 4,
  parameter int NUM_LANES   = 4,
  parameter int DATA_SIZE   = 4,
  parameter int ADDR_WIDTH  = 30,
  parameter int TAG_WIDTH   = 8,
  parameter int MAX_PENDING = 16,
  localparam int SEL_BITS   = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 0,
  localparam int OTAG_WIDTH = TAG_WIDTH + SEL_BITS,
  localparam int PCNT_W     = $clog2(MAX_PENDING + 1)
) (
  input  logic                                          clk,
  input  logic                                          reset,
  input  logic [NUM_REQS-1:0]                           req_valid_in,
  input  logic [NUM_REQS-1:0]                           req_rw_in,
  input  logic [NUM_REQS*NUM_LANES-1:0]                 req_mask_in,
  input  logic [NUM_REQS*NUM_LANES*DATA_SIZE-1:0]       req_byteen_in,
  input  logic [NUM_REQS*NUM_LANES*ADDR_WIDTH-1:0]      req_addr_in,
  input  logic [NUM_REQS*NUM_LANES*8*DATA_SIZE-1:0]     req_data_in,
  input  logic [NUM_REQS*TAG_WIDTH-1:0]                 req_tag_in,
  output logic [NUM_REQS-1:0]                           req_ready_in,
  output logic                                          req_valid_out,
  output logic                                          req_rw_out,
  output logic [NUM_LANES-1:0]                          req_mask_out,
  output logic [NUM_LANES*DATA_SIZE-1:0]                req_byteen_out,
  output logic [NUM_LANES*ADDR_WIDTH-1:0]               req_addr_out,
  output logic [NUM_LANES*8*DATA_SIZE-1:0]              req_data_out,
  output logic [OTAG_WIDTH-1:0]                         req_tag_out,
  input  logic                                          req_ready_out,
  input  logic                                          rsp_valid_in,
  input  logic [NUM_LANES-1:0]                          rsp_mask_in,
  input  logic [NUM_LANES*8*DATA_SIZE-1:0]              rsp_data_in,
  input  logic [OTAG_WIDTH-1:0]                         rsp_tag_in,
  output logic                                          rsp_ready_in,
  output logic [NUM_REQS-1:0]                           rsp_valid_out,
  output logic [NUM_LANES-1:0]                          rsp_mask_out,
  output logic [NUM_LANES*8*DATA_SIZE-1:0]              rsp_data_out,
  output logic [TAG_WIDTH-1:0]                          rsp_tag_out,
  input  logic [NUM_REQS-1:0]                           rsp_ready_out,
  output logic [NUM_REQS*PCNT_W-1:0]                    pending_count,
  output logic                                          busy
);

  localparam int SEL_W = (SEL_BITS > 0) ? SEL_BITS : 1;
  localparam int BE_W  = NUM_LANES * DATA_SIZE;
  localparam int AD_W  = NUM_LANES * ADDR_WIDTH;
  localparam int DT_W  = NUM_LANES * 8 * DATA_SIZE;
  localparam int ENT_W = 1 + NUM_LANES + BE_W + AD_W + DT_W + OTAG_WIDTH;

  logic [PCNT_W-1:0]     pend [NUM_REQS];
  logic [NUM_REQS-1:0]   elig, grant, pend_inc, pend_dec;
  logic [SEL_W-1:0]      rr, win, rsp_sel;
  logic                  found, push, pop, can_push, sel_ok;
  logic [1:0]            fcnt;
  logic [ENT_W-1:0]      ent0, ent1, push_ent;
  logic [OTAG_WIDTH-1:0] otag;

  always_comb begin
    elig = '0;
    for (int unsigned i = 0; i < NUM_REQS; i++)
      elig[i] = req_valid_in[i] && (req_rw_in[i] || (pend[i] < PCNT_W'(MAX_PENDING)));
  end

  // Scan from the priority pointer, wrapping, and take the first eligible requester.
  always_comb begin
    int unsigned idx;
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int unsigned k = 0; k < NUM_REQS; k++) begin
      idx = (32'(rr) + k) % NUM_REQS;
      if (!found && elig[idx]) begin
        found = 1'b1;
        win   = SEL_W'(idx);
      end
    end
  end

  // A full buffer still accepts when its head is leaving this cycle.
  assign pop      = (fcnt != 2'd0) && req_ready_out;
  assign can_push = (fcnt != 2'd2) || pop;
  assign push     = found && can_push && !reset;
  assign grant    = push ? (NUM_REQS'(1) << win) : '0;
  assign req_ready_in = grant;

  generate
    if (SEL_BITS > 0) begin : g_sel
      assign otag    = {req_tag_in[win*TAG_WIDTH +: TAG_WIDTH], win};
      assign rsp_sel = rsp_tag_in[SEL_BITS-1:0];
    end else begin : g_nosel
      assign otag    = req_tag_in[TAG_WIDTH-1:0];
      assign rsp_sel = '0;
    end
  endgenerate

  assign push_ent = {req_rw_in[win],
                     req_mask_in[win*NUM_LANES +: NUM_LANES],
                     req_byteen_in[win*BE_W +: BE_W],
                     req_addr_in[win*AD_W +: AD_W],
                     req_data_in[win*DT_W +: DT_W],
                     otag};

  always_ff @(posedge clk) begin
    if (reset) begin
      fcnt <= '0;
      ent0 <= '0;
      ent1 <= '0;
    end else begin
      case (fcnt)
        2'd0: if (push) begin
          ent0 <= push_ent;
          fcnt <= 2'd1;
        end
        2'd1: if (push && pop) begin
          ent0 <= push_ent;
        end else if (pop) begin
          fcnt <= 2'd0;
        end else if (push) begin
          ent1 <= push_ent;
          fcnt <= 2'd2;
        end
        default: if (pop) begin
          ent0 <= ent1;
          if (push) ent1 <= push_ent;
          else      fcnt <= 2'd1;
        end
      endcase
    end
  end

  assign req_valid_out = (fcnt != 2'd0);
  assign {req_rw_out, req_mask_out, req_byteen_out, req_addr_out, req_data_out, req_tag_out} = ent0;

  always_ff @(posedge clk) begin
    if (reset)     rr <= '0;
    else if (push) rr <= (int'(win) == NUM_REQS - 1) ? '0 : win + 1'b1;
  end

  assign sel_ok        = int'(rsp_sel) < NUM_REQS;
  assign rsp_ready_in  = sel_ok && rsp_ready_out[rsp_sel];
  assign rsp_valid_out = (rsp_valid_in && sel_ok) ? (NUM_REQS'(1) << rsp_sel) : '0;
  assign rsp_tag_out   = rsp_tag_in[OTAG_WIDTH-1 -: TAG_WIDTH];
  assign rsp_mask_out  = rsp_mask_in;
  assign rsp_data_out  = rsp_data_in;

  assign pend_inc = grant & ~req_rw_in;
  assign pend_dec = rsp_valid_out & {NUM_REQS{rsp_ready_in}};

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NUM_REQS; i++) begin
      if (reset) begin
        pend[i] <= '0;
      end else begin
        assert (!(pend_dec[i] && pend[i] == '0))
          else $error("response retired for requester %0d with no pending load", i);
        assert (!(pend_inc[i] && !pend_dec[i] && pend[i] == PCNT_W'(MAX_PENDING)))
          else $error("pending counter overflow on requester %0d", i);
        if (pend_inc[i] && !pend_dec[i])      pend[i] <= pend[i] + 1'b1;
        else if (pend_dec[i] && !pend_inc[i]) pend[i] <= pend[i] - 1'b1;
      end
    end
  end

  always_comb begin
    busy = (fcnt != 2'd0);
    for (int unsigned i = 0; i < NUM_REQS; i++)
      if (pend[i] != '0) busy = 1'b1;
  end

  generate
    for (genvar g = 0; g < NUM_REQS; g++) begin : g_pcnt
      assign pending_count[g*PCNT_W +: PCNT_W] = pend[g];
    end
  endgenerate

endmodule

// File: tb/tb_lsu_block_arbiter.sv
// Scenario bench for lsu_block_arbiter: expected packets are queued as stimulus is granted
// and compared in order when the merged request port fires.
module tb_lsu_block_arbiter;
  localparam int N = 4, L = 4, DS = 4, AW = 30, TW = 8, MP = 16;
  localparam int SB = 2, OTW = TW + SB, PW = 5;
  localparam int PKT_W = 1 + L + L*DS + L*AW + L*8*DS + OTW;

  logic clk = 1'b0;
  logic reset;
  logic [N-1:0]       req_valid_in, req_rw_in, req_ready_in;
  logic [N*L-1:0]     req_mask_in;
  logic [N*L*DS-1:0]  req_byteen_in;
  logic [N*L*AW-1:0]  req_addr_in;
  logic [N*L*32-1:0]  req_data_in;
  logic [N*TW-1:0]    req_tag_in;
  logic               req_valid_out, req_rw_out, req_ready_out;
  logic [L-1:0]       req_mask_out;
  logic [L*DS-1:0]    req_byteen_out;
  logic [L*AW-1:0]    req_addr_out;
  logic [L*32-1:0]    req_data_out;
  logic [OTW-1:0]     req_tag_out;
  logic               rsp_valid_in, rsp_ready_in;
  logic [L-1:0]       rsp_mask_in, rsp_mask_out;
  logic [L*32-1:0]    rsp_data_in, rsp_data_out;
  logic [OTW-1:0]     rsp_tag_in;
  logic [N-1:0]       rsp_valid_out, rsp_ready_out;
  logic [TW-1:0]      rsp_tag_out;
  logic [N*PW-1:0]    pending_count;
  logic               busy;

  lsu_block_arbiter #(
    .NUM_REQS(N), .NUM_LANES(L), .DATA_SIZE(DS), .ADDR_WIDTH(AW), .TAG_WIDTH(TW), .MAX_PENDING(MP)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid_in(req_valid_in), .req_rw_in(req_rw_in), .req_mask_in(req_mask_in),
    .req_byteen_in(req_byteen_in), .req_addr_in(req_addr_in), .req_data_in(req_data_in),
    .req_tag_in(req_tag_in), .req_ready_in(req_ready_in),
    .req_valid_out(req_valid_out), .req_rw_out(req_rw_out), .req_mask_out(req_mask_out),
    .req_byteen_out(req_byteen_out), .req_addr_out(req_addr_out), .req_data_out(req_data_out),
    .req_tag_out(req_tag_out), .req_ready_out(req_ready_out),
    .rsp_valid_in(rsp_valid_in), .rsp_mask_in(rsp_mask_in), .rsp_data_in(rsp_data_in),
    .rsp_tag_in(rsp_tag_in), .rsp_ready_in(rsp_ready_in),
    .rsp_valid_out(rsp_valid_out), .rsp_mask_out(rsp_mask_out), .rsp_data_out(rsp_data_out),
    .rsp_tag_out(rsp_tag_out), .rsp_ready_out(rsp_ready_out),
    .pending_count(pending_count), .busy(busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [PKT_W-1:0] exp_q[$];
  logic [PKT_W-1:0] mon_exp, mon_act;
  logic [N-1:0] v, rw, g;
  int seq[N];
  int model_pend[N];

  function automatic logic [TW-1:0] f_tag(int i, int s);
    return TW'(i*37 + s*5 + 1);
  endfunction

  function automatic logic [PKT_W-1:0] f_pkt(int i);
    logic [L-1:0] m;
    logic [L*DS-1:0] be;
    logic [L*AW-1:0] a;
    logic [L*32-1:0] d;
    m = L'((i + seq[i]) | 1);
    for (int l = 0; l < L; l++) begin
      be[l*DS +: DS] = DS'(seq[i] + l + i);
      a[l*AW +: AW]  = AW'((i << 24) | ((seq[i] & 255) << 8) | l);
      d[l*32 +: 32]  = 32'hD000_0000 | 32'(i << 16) | 32'((seq[i] & 255) << 4) | 32'(l);
    end
    return {rw[i], m, be, a, d, f_tag(i, seq[i]), SB'(i)};
  endfunction

  task automatic apply();
    logic [PKT_W-1:0] p;
    for (int i = 0; i < N; i++) begin
      p = f_pkt(i);
      req_valid_in[i] = v[i];
      req_rw_in[i]    = rw[i];
      req_mask_in[i*L +: L]         = p[PKT_W-2 -: L];
      req_byteen_in[i*L*DS +: L*DS] = p[PKT_W-2-L -: L*DS];
      req_addr_in[i*L*AW +: L*AW]   = p[PKT_W-2-L-L*DS -: L*AW];
      req_data_in[i*L*32 +: L*32]   = p[OTW +: L*32];
      req_tag_in[i*TW +: TW]        = f_tag(i, seq[i]);
    end
  endtask

  // One clock; exp_w is the requester the bench expects to win this cycle (-1: none).
  task automatic step(input int exp_w, output logic [N-1:0] obs);
    @(negedge clk);
    obs = req_ready_in;
    if (exp_w >= 0) begin
      exp_q.push_back(f_pkt(exp_w));
      if (!rw[exp_w]) model_pend[exp_w]++;
    end
    @(posedge clk); #1;
    if (exp_w >= 0) seq[exp_w]++;
    apply();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    v = '0; rw = '0; apply();
    rsp_valid_in = 1'b0; rsp_tag_in = '0; rsp_mask_in = '0; rsp_data_in = '0;
    rsp_ready_out = '1; req_ready_out = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    exp_q.delete();
    for (int i = 0; i < N; i++) model_pend[i] = 0;
  endtask

  always @(negedge clk) begin
    if (!reset && req_valid_out && req_ready_out) begin
      checks++;
      mon_act = {req_rw_out, req_mask_out, req_byteen_out, req_addr_out, req_data_out, req_tag_out};
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL out_unexpected: got %h with nothing expected", mon_act);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_act !== mon_exp) begin
          errors++;
          $display("FAIL out_packet: got %h expected %h", mon_act, mon_exp);
        end
      end
    end
  end

  task automatic test_reset();
    reset = 1'b1;
    v = '1; rw = '0; apply();
    rsp_valid_in = 1'b0; rsp_tag_in = '0; rsp_mask_in = '0; rsp_data_in = '0;
    rsp_ready_out = '1; req_ready_out = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (req_valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid_out: %b expected 0", req_valid_out); end
    checks++; if (req_ready_in !== 4'b0) begin errors++; $display("FAIL reset_ready_in: %b expected 0000", req_ready_in); end
    checks++; if (rsp_valid_out !== 4'b0) begin errors++; $display("FAIL reset_rsp_valid: %b expected 0000", rsp_valid_out); end
    checks++; if (pending_count !== '0) begin errors++; $display("FAIL reset_pending: %h expected 0", pending_count); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: %b expected 0", busy); end
    v = '0; apply();
    reset = 1'b0;
    for (int i = 0; i < N; i++) begin seq[i] = 0; model_pend[i] = 0; end
  endtask

  task automatic test_round_robin();
    do_reset();
    v = 4'b1111; rw = '0; apply();
    checks++; if (req_valid_out !== 1'b0) begin errors++; $display("FAIL rr_idle_out: %b expected 0", req_valid_out); end
    for (int k = 0; k < 8; k++) begin
      step(k % 4, g);
      checks++;
      if (g !== 4'(1 << (k % 4))) begin errors++; $display("FAIL rr_order[%0d]: req_ready_in=%b expected %b", k, g, 4'(1 << (k % 4))); end
      if (k == 0) begin
        checks++; if (req_valid_out !== 1'b1) begin errors++; $display("FAIL rr_latency: req_valid_out=%b expected 1", req_valid_out); end
      end
    end
    v = '0; apply();
    for (int i = 0; i < N; i++) begin
      checks++;
      if (pending_count[i*PW +: PW] !== PW'(model_pend[i])) begin errors++; $display("FAIL rr_pending[%0d]: %0d expected %0d", i, pending_count[i*PW +: PW], model_pend[i]); end
    end
    repeat (2) step(-1, g);
    checks++; if (exp_q.size() != 0 || req_valid_out !== 1'b0) begin errors++; $display("FAIL rr_drain: left=%0d valid_out=%b expected 0/0", exp_q.size(), req_valid_out); end
  endtask

  task automatic test_rr_skip();
    int want[5] = '{1, 3, 1, 3, 1};
    do_reset();
    rw = '0;
    for (int k = 0; k < 5; k++) begin
      v = (k == 0) ? 4'b0010 : 4'b1010; apply();
      step(want[k], g);
      checks++;
      if (g !== 4'(1 << want[k])) begin errors++; $display("FAIL skip_order[%0d]: req_ready_in=%b expected %b", k, g, 4'(1 << want[k])); end
    end
    v = 4'b1111; apply();
    step(2, g);
    checks++; if (g !== 4'b0100) begin errors++; $display("FAIL skip_rr_end: req_ready_in=%b expected 0100", g); end
    v = '0; apply();
    repeat (2) step(-1, g);
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL skip_drain: left=%0d expected 0", exp_q.size()); end
  endtask

  task automatic test_pending_limit();
    do_reset();
    v = 4'b0001; rw = 4'b0010; apply();
    for (int k = 0; k < MP; k++) begin
      step(0, g);
      checks++; if (g !== 4'b0001) begin errors++; $display("FAIL lim_fill[%0d]: req_ready_in=%b expected 0001", k, g); end
    end
    checks++; if (pending_count[PW-1:0] !== PW'(MP)) begin errors++; $display("FAIL lim_count_full: %0d expected %0d", pending_count[PW-1:0], MP); end
    v = 4'b0011; apply();
    for (int k = 0; k < 3; k++) begin
      step(1, g);
      checks++; if (g !== 4'b0010) begin errors++; $display("FAIL lim_store[%0d]: req_ready_in=%b expected 0010", k, g); end
    end
    v = 4'b0001; apply();
    step(-1, g);
    checks++; if (g !== 4'b0000) begin errors++; $display("FAIL lim_stalled: req_ready_in=%b expected 0000", g); end
    rsp_valid_in = 1'b1; rsp_tag_in = {8'h11, 2'd0}; rsp_ready_out = 4'b0001;
    #1;
    checks++; if (rsp_ready_in !== 1'b1 || rsp_valid_out !== 4'b0001) begin errors++; $display("FAIL lim_rsp: ready=%b valid=%b expected 1/0001", rsp_ready_in, rsp_valid_out); end
    model_pend[0]--;
    step(-1, g);
    checks++; if (g !== 4'b0000) begin errors++; $display("FAIL lim_rsp_cycle: req_ready_in=%b expected 0000", g); end
    rsp_valid_in = 1'b0; rsp_ready_out = '1;
    checks++; if (pending_count[PW-1:0] !== PW'(MP-1)) begin errors++; $display("FAIL lim_retired: %0d expected %0d", pending_count[PW-1:0], MP-1); end
    step(0, g);
    checks++; if (g !== 4'b0001) begin errors++; $display("FAIL lim_resume: req_ready_in=%b expected 0001", g); end
    v = '0; apply();
    repeat (2) step(-1, g);
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL lim_drain: left=%0d expected 0", exp_q.size()); end
  endtask

  task automatic test_backpressure();
    int want[5] = '{0, 1, -1, -1, -1};
    logic [OTW-1:0] head;
    do_reset();
    req_ready_out = 1'b0;
    v = 4'b1111; rw = '0; apply();
    head = {f_tag(0, seq[0]), 2'd0};
    for (int k = 0; k < 5; k++) begin
      step(want[k], g);
      checks++;
      if (g !== ((want[k] < 0) ? 4'b0 : 4'(1 << want[k]))) begin errors++; $display("FAIL bp_grant[%0d]: req_ready_in=%b expected winner %0d", k, g, want[k]); end
      checks++;
      if (req_valid_out !== 1'b1 || req_tag_out !== head) begin errors++; $display("FAIL bp_hold[%0d]: valid=%b tag=%h expected 1/%h", k, req_valid_out, req_tag_out, head); end
    end
    v = '0; apply();
    req_ready_out = 1'b1;
    repeat (3) step(-1, g);
    checks++; if (exp_q.size() != 0 || req_valid_out !== 1'b0) begin errors++; $display("FAIL bp_drain: left=%0d valid_out=%b expected 0/0", exp_q.size(), req_valid_out); end
    for (int i = 0; i < N; i++) begin
      checks++;
      if (pending_count[i*PW +: PW] !== PW'(model_pend[i])) begin errors++; $display("FAIL bp_pending[%0d]: %0d expected %0d", i, pending_count[i*PW +: PW], model_pend[i]); end
    end
  endtask

  task automatic test_response();
    do_reset();
    v = 4'b0100; rw = '0; apply();
    step(2, g); step(2, g);
    v = '0; apply();
    rsp_valid_in = 1'b1; rsp_tag_in = {8'h5A, 2'd2}; rsp_ready_out = 4'b0100;
    rsp_mask_in = 4'b1010; rsp_data_in = {32'h1111_2222, 32'h3333_4444, 32'h5555_6666, 32'h7777_8888};
    #1;
    checks++; if (rsp_valid_out !== 4'b0100) begin errors++; $display("FAIL rsp_valid: %b expected 0100", rsp_valid_out); end
    checks++; if (rsp_tag_out !== 8'h5A) begin errors++; $display("FAIL rsp_tag: %h expected 5a", rsp_tag_out); end
    checks++; if (rsp_ready_in !== 1'b1) begin errors++; $display("FAIL rsp_ready: %b expected 1", rsp_ready_in); end
    checks++; if (rsp_mask_out !== 4'b1010 || rsp_data_out !== 128'h1111_2222_3333_4444_5555_6666_7777_8888) begin errors++; $display("FAIL rsp_bcast: mask=%b data=%h", rsp_mask_out, rsp_data_out); end
    model_pend[2]--;
    step(-1, g);
    checks++; if (pending_count[2*PW +: PW] !== 5'd1) begin errors++; $display("FAIL rsp_dec: %0d expected 1", pending_count[2*PW +: PW]); end
    rsp_ready_out = 4'b1011;
    #1;
    checks++; if (rsp_ready_in !== 1'b0 || rsp_valid_out !== 4'b0100) begin errors++; $display("FAIL rsp_blocked: ready=%b valid=%b expected 0/0100", rsp_ready_in, rsp_valid_out); end
    step(-1, g);
    checks++; if (pending_count[2*PW +: PW] !== 5'd1) begin errors++; $display("FAIL rsp_nofire: %0d expected 1", pending_count[2*PW +: PW]); end
    rsp_ready_out = 4'b0100;
    v = 4'b0100; apply();
    model_pend[2]--;
    step(2, g);
    checks++; if (g !== 4'b0100) begin errors++; $display("FAIL rsp_same_grant: %b expected 0100", g); end
    checks++; if (pending_count[2*PW +: PW] !== 5'd1) begin errors++; $display("FAIL rsp_same_cycle: %0d expected 1", pending_count[2*PW +: PW]); end
    v = '0; apply();
    model_pend[2]--;
    step(-1, g);
    rsp_valid_in = 1'b0; rsp_ready_out = '1;
    step(-1, g);
    checks++; if (pending_count !== '0 || busy !== 1'b0 || exp_q.size() != 0) begin errors++; $display("FAIL rsp_idle: pending=%h busy=%b left=%0d expected 0/0/0", pending_count, busy, exp_q.size()); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    req_ready_out = 1'b0;
    v = 4'b0011; rw = '0; apply();
    step(0, g); step(1, g);
    checks++; if (busy !== 1'b1 || req_valid_out !== 1'b1) begin errors++; $display("FAIL mid_loaded: busy=%b valid=%b expected 1/1", busy, req_valid_out); end
    reset = 1'b1;
    @(posedge clk); #1;
    checks++; if (req_valid_out !== 1'b0) begin errors++; $display("FAIL mid_valid_out: %b expected 0", req_valid_out); end
    checks++; if (req_ready_in !== 4'b0) begin errors++; $display("FAIL mid_ready_in: %b expected 0000", req_ready_in); end
    checks++; if (pending_count !== '0 || busy !== 1'b0) begin errors++; $display("FAIL mid_counts: pending=%h busy=%b expected 0/0", pending_count, busy); end
    exp_q.delete();
    for (int i = 0; i < N; i++) model_pend[i] = 0;
    v = '0; apply();
    reset = 1'b0;
    req_ready_out = 1'b1;
    step(-1, g);
    checks++; if (req_valid_out !== 1'b0 || rsp_valid_out !== 4'b0) begin errors++; $display("FAIL mid_after: valid=%b rsp_valid=%b expected 0/0000", req_valid_out, rsp_valid_out); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_round_robin();
    test_rr_skip();
    test_pending_limit();
    test_backpressure();
    test_response();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
